// File: rtl/dragon_pursuit_fsm.sv
// Dragon head behaviour FSM and tile movement engine for the playfield.
// One update per enabled frame_clk edge; every output comes straight from a register.
module dragon_pursuit_fsm #(
  parameter int                     COORD_W   = 4,
  parameter int                     LEN_W     = 4,
  parameter int                     MAX_LEN   = 15,
  parameter int                     INIT_LEN  = 3,
  parameter int                     STEP_DIV  = 4,
  parameter logic [2*COORD_W-1:0]   RESET_POS = 8'h88,
  parameter logic [15:0]            LFSR_SEED = 16'hACE1
) (
  input  logic                   frame_clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [2*COORD_W-1:0]   player_pos,
  input  logic [2*COORD_W-1:0]   sheep_pos,
  input  logic                   dragon_hurt,
  output logic [2*COORD_W-1:0]   head_pos,
  output logic [1:0]             head_dir,
  output logic [LEN_W-1:0]       body_len,
  output logic [1:0]             state,
  output logic                   move_strobe,
  output logic                   sheep_eaten,
  output logic                   player_hit
);

  localparam int PW    = 2 * COORD_W;
  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    CONTEST = 2'd0,
    RETREAT = 2'd1,
    SCATTER = 2'd2,
    DEAD    = 2'd3
  } state_t;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [COORD_W:0] manhattan(input logic [PW-1:0] p,
                                                 input logic [PW-1:0] q);
    return {1'b0, abs_diff(p[PW-1:COORD_W], q[PW-1:COORD_W])} +
           {1'b0, abs_diff(p[COORD_W-1:0], q[COORD_W-1:0])};
  endfunction

  // Corners are scanned in tie-break order; only a strictly larger distance displaces the earlier one.
  function automatic logic [PW-1:0] far_corner(input logic [PW-1:0] p);
    logic [PW-1:0]      best;
    logic [PW-1:0]      cand;
    logic [COORD_W:0]   best_d;
    logic [COORD_W:0]   d;
    logic [COORD_W-1:0] lo;
    logic [COORD_W-1:0] hi;
    lo     = {COORD_W{1'b0}};
    hi     = {COORD_W{1'b1}};
    best   = {lo, lo};
    best_d = manhattan(p, best);
    for (int i = 1; i < 4; i++) begin
      cand = {(i[1] ? hi : lo), (i[0] ? hi : lo)};
      d    = manhattan(p, cand);
      if (d > best_d) begin
        best   = cand;
        best_d = d;
      end else begin
        best   = best;
      end
    end
    return best;
  endfunction

  state_t             state_r, state_s;
  logic [PW-1:0]      head_r, head_s, target_r, target_s;
  logic [1:0]         dir_r, dir_s;
  logic [LEN_W-1:0]   len_r, len_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [15:0]        lfsr_r, lfsr_s;
  logic               strobe_r, strobe_s, eaten_r, eaten_s, hit_r, hit_s;

  logic               step_edge_s, lfsr_fb_s, move_valid_s;
  logic [PW-1:0]      chase_s, move_head_s;
  logic [1:0]         move_dir_s;
  logic [COORD_W-1:0] hx_s, hy_s, tx_s, ty_s, dx_s, dy_s;

  assign step_edge_s = (cnt_r == CNT_W'(STEP_DIV - 1));
  assign lfsr_fb_s   = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
  assign hx_s        = head_r[COORD_W-1:0];
  assign hy_s        = head_r[PW-1:COORD_W];
  assign tx_s        = chase_s[COORD_W-1:0];
  assign ty_s        = chase_s[PW-1:COORD_W];
  assign dx_s        = abs_diff(hx_s, tx_s);
  assign dy_s        = abs_diff(hy_s, ty_s);

  // Target selection: live nearest-of-two in CONTEST (tie -> sheep), latched target otherwise.
  always_comb begin
    chase_s = target_r;
    if (state_r == CONTEST) begin
      chase_s = (manhattan(head_r, player_pos) < manhattan(head_r, sheep_pos)) ?
                player_pos : sheep_pos;
    end else begin
      chase_s = target_r;
    end
  end

  // Single-tile step along the axis with the larger gap; equal gaps resolve to X.
  always_comb begin
    move_head_s  = head_r;
    move_dir_s   = dir_r;
    move_valid_s = 1'b0;
    if (dy_s > dx_s) begin
      move_valid_s = 1'b1;
      if (ty_s > hy_s) begin
        move_head_s = {hy_s + COORD_W'(1), hx_s};
        move_dir_s  = DIR_DOWN;
      end else begin
        move_head_s = {hy_s - COORD_W'(1), hx_s};
        move_dir_s  = DIR_UP;
      end
    end else if (dx_s != {COORD_W{1'b0}}) begin
      move_valid_s = 1'b1;
      if (tx_s > hx_s) begin
        move_head_s = {hy_s, hx_s + COORD_W'(1)};
        move_dir_s  = DIR_RIGHT;
      end else begin
        move_head_s = {hy_s, hx_s - COORD_W'(1)};
        move_dir_s  = DIR_LEFT;
      end
    end else begin
      move_valid_s = 1'b0;
    end
  end

  // Next-state logic: hurt outranks stepping; DEAD only leaves through rst_n.
  always_comb begin
    state_s  = state_r;
    head_s   = head_r;
    target_s = target_r;
    dir_s    = dir_r;
    len_s    = len_r;
    cnt_s    = cnt_r;
    lfsr_s   = lfsr_r;
    strobe_s = 1'b0;
    eaten_s  = 1'b0;
    hit_s    = 1'b0;
    if (enable) begin
      lfsr_s = {lfsr_r[14:0], lfsr_fb_s};
      cnt_s  = step_edge_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      if (state_r == DEAD) begin
        state_s = DEAD;
      end else if (dragon_hurt) begin
        len_s = len_r - LEN_W'(1);
        if (len_r == LEN_W'(1)) begin
          state_s = DEAD;
        end else begin
          state_s  = RETREAT;
          target_s = far_corner(player_pos);
        end
      end else if (step_edge_s) begin
        head_s   = move_head_s;
        dir_s    = move_dir_s;
        strobe_s = move_valid_s;
        case (state_r)
          CONTEST: begin
            if (move_head_s == player_pos) begin
              hit_s    = 1'b1;
              state_s  = SCATTER;
              target_s = lfsr_r[PW-1:0];
            end else if (move_head_s == sheep_pos) begin
              eaten_s  = 1'b1;
              state_s  = SCATTER;
              target_s = lfsr_r[PW-1:0];
              len_s    = (len_r >= LEN_W'(MAX_LEN)) ? len_r : len_r + LEN_W'(1);
            end else begin
              state_s = CONTEST;
            end
          end
          RETREAT, SCATTER: state_s = (move_head_s == target_r) ? CONTEST : state_r;
          default:          state_s = state_r;
        endcase
      end else begin
        state_s = state_r;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers.
  always_ff @(posedge frame_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= SCATTER;
      head_r   <= RESET_POS;
      target_r <= LFSR_SEED[PW-1:0];
      dir_r    <= DIR_UP;
      len_r    <= LEN_W'(INIT_LEN);
      cnt_r    <= {CNT_W{1'b0}};
      lfsr_r   <= LFSR_SEED;
      strobe_r <= 1'b0;
      eaten_r  <= 1'b0;
      hit_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      head_r   <= head_s;
      target_r <= target_s;
      dir_r    <= dir_s;
      len_r    <= len_s;
      cnt_r    <= cnt_s;
      lfsr_r   <= lfsr_s;
      strobe_r <= strobe_s;
      eaten_r  <= eaten_s;
      hit_r    <= hit_s;
    end
  end

  assign head_pos    = head_r;
  assign head_dir    = dir_r;
  assign body_len    = len_r;
  assign state       = state_r;
  assign move_strobe = strobe_r;
  assign sheep_eaten = eaten_r;
  assign player_hit  = hit_r;

endmodule
